// File: rtl/rns_op_sequencer.sv
// Request sequencer for one residue channel: issues add/sub/mul to external units,
// steers the result mux, waits (with timeout) on the multiplier and holds the response.
module rns_op_sequencer #(
   parameter int MUL_TIMEOUT = 15,
   parameter int W           = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [1:0]   req_op,
   input  logic [W-1:0] req_a,
   input  logic [W-1:0] req_b,
   output logic [W-1:0] op_a,
   output logic [W-1:0] op_b,
   output logic         mul_start,
   input  logic         mul_done,
   output logic         s0,
   output logic         s1,
   input  logic [W-1:0] mux_result,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_result,
   output logic         rsp_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_MUL, RESP} state_t;

   localparam logic [7:0] TMO_LAST = 8'(MUL_TIMEOUT - 1);

   state_t     state;
   logic [1:0] op_q;
   logic [7:0] tmo_count;

   // All outputs are registered; each one is set on the transition into the state
   // where it must be visible, so req_ready/rsp_valid/mul_start/mux selects track state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         mul_start  <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_result <= '0;
         op_a       <= '0;
         op_b       <= '0;
         s1         <= 1'b1;
         s0         <= 1'b1;
         op_q       <= 2'b11;
         tmo_count  <= '0;
      end else begin
         mul_start <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_a      <= req_a;
                  op_b      <= req_b;
                  op_q      <= req_op;
                  {s1, s0}  <= req_op;
                  mul_start <= (req_op == 2'b10);
                  req_ready <= 1'b0;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               case (op_q)
                  2'b00, 2'b01: begin
                     rsp_result <= mux_result;
                     rsp_err    <= 1'b0;
                     rsp_valid  <= 1'b1;
                     state      <= RESP;
                  end
                  2'b10: begin
                     tmo_count <= '0;
                     state     <= WAIT_MUL;
                  end
                  default: begin
                     rsp_result <= '0;
                     rsp_err    <= 1'b1;
                     rsp_valid  <= 1'b1;
                     state      <= RESP;
                  end
               endcase
            end
            // A done arriving on the timeout cycle still counts as a good result.
            WAIT_MUL: begin
               if (mul_done) begin
                  rsp_result <= mux_result;
                  rsp_err    <= 1'b0;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end else if (tmo_count == TMO_LAST) begin
                  rsp_result <= '0;
                  rsp_err    <= 1'b1;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end else begin
                  tmo_count <= tmo_count + 8'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  {s1, s0}  <= 2'b11;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rns_op_sequencer.sv
// Directed bench for rns_op_sequencer: add, mul, timeout, late-done, illegal op,
// backpressure and reset in the middle of a multiply.
module tb_rns_op_sequencer;

   localparam int W = 7;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   logic [1:0]   req_op;
   logic [W-1:0] req_a;
   logic [W-1:0] req_b;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         mul_start;
   logic         mul_done;
   logic         s0;
   logic         s1;
   logic [W-1:0] mux_result;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_result;
   logic         rsp_err;

   int vectors = 0;
   int miscompares = 0;
   int start_pulses = 0;
   int start_before;

   rns_op_sequencer #(.MUL_TIMEOUT(15), .W(W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
      .mul_start(mul_start), .mul_done(mul_done), .s0(s0), .s1(s1),
      .mux_result(mux_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mul_start === 1'b1) start_pulses <= start_pulses + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [1:0] op,
                                input logic [W-1:0] a, input logic [W-1:0] b);
      req_valid = valid;
      req_op    = op;
      req_a     = a;
      req_b     = b;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, " req_ready"}, 32'(req_ready), 1);
      checkOutput({tag, " rsp_valid"}, 32'(rsp_valid), 0);
      checkOutput({tag, " mul_start"}, 32'(mul_start), 0);
      checkOutput({tag, " rsp_err"}, 32'(rsp_err), 0);
      checkOutput({tag, " rsp_result"}, 32'(rsp_result), 0);
      checkOutput({tag, " op_a"}, 32'(op_a), 0);
      checkOutput({tag, " op_b"}, 32'(op_b), 0);
      checkOutput({tag, " sel"}, 32'({s1, s0}), 3);
   endtask

   initial begin
      rst        = 1'b1;
      mul_done   = 1'b0;
      rsp_ready  = 1'b0;
      mux_result = '0;
      applyStimulus(1'b0, 2'b00, '0, '0);
      tick();
      checkReset("reset");
      @(negedge clk);
      rst = 1'b0;
      tick();

      $display("[TB] add");
      applyStimulus(1'b1, 2'b00, 7'd5, 7'd3);
      mux_result = 7'd8;
      tick();
      applyStimulus(1'b0, 2'b00, '0, '0);
      checkOutput("add issue req_ready", 32'(req_ready), 0);
      checkOutput("add op_a", 32'(op_a), 5);
      checkOutput("add op_b", 32'(op_b), 3);
      checkOutput("add sel", 32'({s1, s0}), 0);
      checkOutput("add issue rsp_valid", 32'(rsp_valid), 0);
      tick();
      checkOutput("add rsp_valid", 32'(rsp_valid), 1);
      checkOutput("add rsp_result", 32'(rsp_result), 8);
      checkOutput("add rsp_err", 32'(rsp_err), 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput("add idle rsp_valid", 32'(rsp_valid), 0);
      checkOutput("add idle req_ready", 32'(req_ready), 1);
      checkOutput("add idle sel", 32'({s1, s0}), 3);

      $display("[TB] mul");
      start_before = start_pulses;
      applyStimulus(1'b1, 2'b10, 7'd9, 7'd4);
      mux_result = 7'h55;
      tick();
      applyStimulus(1'b0, 2'b00, '0, '0);
      checkOutput("mul start high", 32'(mul_start), 1);
      checkOutput("mul sel", 32'({s1, s0}), 2);
      tick();
      checkOutput("mul start low", 32'(mul_start), 0);
      tick();
      tick();
      checkOutput("mul waiting rsp_valid", 32'(rsp_valid), 0);
      mul_done   = 1'b1;
      mux_result = 7'd36;
      tick();
      mul_done = 1'b0;
      checkOutput("mul rsp_valid", 32'(rsp_valid), 1);
      checkOutput("mul rsp_result", 32'(rsp_result), 36);
      checkOutput("mul rsp_err", 32'(rsp_err), 0);
      checkOutput("mul sel resp", 32'({s1, s0}), 2);
      checkOutput("mul start pulses", 32'(start_pulses - start_before), 1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      $display("[TB] timeout");
      applyStimulus(1'b1, 2'b10, 7'd2, 7'd6);
      mux_result = 7'h2A;
      tick();
      applyStimulus(1'b0, 2'b00, '0, '0);
      tick();
      for (int i = 0; i < 14; i++) tick();
      checkOutput("timeout cycle15 rsp_valid", 32'(rsp_valid), 0);
      tick();
      checkOutput("timeout rsp_valid", 32'(rsp_valid), 1);
      checkOutput("timeout rsp_result", 32'(rsp_result), 0);
      checkOutput("timeout rsp_err", 32'(rsp_err), 1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      $display("[TB] done on timeout cycle");
      applyStimulus(1'b1, 2'b10, 7'd7, 7'd7);
      mux_result = 7'h2A;
      tick();
      applyStimulus(1'b0, 2'b00, '0, '0);
      tick();
      for (int i = 0; i < 14; i++) tick();
      mul_done   = 1'b1;
      mux_result = 7'h33;
      tick();
      mul_done = 1'b0;
      checkOutput("late done rsp_valid", 32'(rsp_valid), 1);
      checkOutput("late done rsp_result", 32'(rsp_result), 'h33);
      checkOutput("late done rsp_err", 32'(rsp_err), 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      $display("[TB] illegal");
      start_before = start_pulses;
      applyStimulus(1'b1, 2'b11, 7'd1, 7'd2);
      mux_result = 7'h7F;
      tick();
      applyStimulus(1'b0, 2'b00, '0, '0);
      checkOutput("illegal issue mul_start", 32'(mul_start), 0);
      checkOutput("illegal sel", 32'({s1, s0}), 3);
      tick();
      checkOutput("illegal rsp_valid", 32'(rsp_valid), 1);
      checkOutput("illegal rsp_err", 32'(rsp_err), 1);
      checkOutput("illegal rsp_result", 32'(rsp_result), 0);
      checkOutput("illegal start pulses", 32'(start_pulses - start_before), 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      $display("[TB] backpressure");
      applyStimulus(1'b1, 2'b01, 7'd10, 7'd4);
      mux_result = 7'd6;
      tick();
      applyStimulus(1'b0, 2'b00, '0, '0);
      checkOutput("sub sel", 32'({s1, s0}), 1);
      tick();
      checkOutput("sub rsp_result", 32'(rsp_result), 6);
      mux_result = 7'h11;
      applyStimulus(1'b1, 2'b00, 7'd99, 7'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("bp rsp_valid", 32'(rsp_valid), 1);
         checkOutput("bp rsp_result", 32'(rsp_result), 6);
         checkOutput("bp rsp_err", 32'(rsp_err), 0);
         checkOutput("bp req_ready", 32'(req_ready), 0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput("bp exit rsp_valid", 32'(rsp_valid), 0);
      checkOutput("bp exit req_ready", 32'(req_ready), 1);
      checkOutput("bp no turnaround op_a", 32'(op_a), 10);
      applyStimulus(1'b0, 2'b00, '0, '0);
      tick();

      $display("[TB] reset mid-mul");
      applyStimulus(1'b1, 2'b10, 7'd3, 7'd5);
      tick();
      applyStimulus(1'b0, 2'b00, '0, '0);
      tick();
      tick();
      rst = 1'b1;
      #2;
      checkReset("async reset");
      #2;
      rst        = 1'b0;
      mul_done   = 1'b1;
      mux_result = 7'd15;
      tick();
      tick();
      mul_done = 1'b0;
      checkReset("after reset");

      $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rns_op_sequencer.md
RNS_OP_SEQUENCER -- requirements
Module: rns_op_sequencer

Interface
REQ-001 Parameter MUL_TIMEOUT, default 15, max cycles to wait for mul_done after start (1..255).
REQ-002 Parameter W, default 7, residue channel width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  sequencer can accept a request.
REQ-007 req_op  input  2  00 add, 01 sub, 10 mul, 11 illegal.
REQ-008 req_a, req_b  input  W each  residue operands.
REQ-009 op_a, op_b  output  W each  registered operands driven to add/sub/mul units.
REQ-010 mul_start  output  1  one-cycle start pulse to the multi-cycle multiplier.
REQ-011 mul_done  input  1  multiplier result valid (level or pulse).
REQ-012 s0, s1  output  1 each  select for the 4:1 result mux: {s1,s0} 00 add, 01 sub, 10 mul, 11 zero.
REQ-013 mux_result  input  W  output of the result mux.
REQ-014 rsp_valid  output  1  response held until accepted.
REQ-015 rsp_ready  input  1  consumer accepts response.
REQ-016 rsp_result  output  W  captured result.
REQ-017 rsp_err  output  1  illegal opcode or multiplier timeout.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT_MUL, RESP; exactly one request in flight.
REQ-019 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready on a rising edge.
REQ-020 On handshake the block SHALL register req_a/req_b into op_a/op_b, latch req_op, go to ISSUE.
REQ-021 In ISSUE with op 00/01 the block SHALL capture mux_result into rsp_result, rsp_err=0, go to RESP (rsp_valid at handshake+2 cycles).
REQ-022 In ISSUE with op 10 the block SHALL assert mul_start for exactly that cycle, clear the timeout counter, go to WAIT_MUL.
REQ-023 In WAIT_MUL, on the first cycle mul_done=1 the block SHALL capture mux_result, rsp_err=0, go to RESP.
REQ-024 In WAIT_MUL the counter SHALL increment each cycle mul_done=0; on reaching MUL_TIMEOUT: rsp_result=0, rsp_err=1, go to RESP; mul_done on that same cycle wins (normal capture).
REQ-025 In ISSUE with op 11 the block SHALL set rsp_result=0, rsp_err=1, go to RESP without touching mul_start.
REQ-026 {s1,s0} SHALL equal the latched op in ISSUE, WAIT_MUL and RESP (11 for illegal op) and 11 in IDLE.
REQ-027 rsp_valid SHALL be 1 only in RESP; rsp_result/rsp_err SHALL be stable while rsp_valid=1 and rsp_ready=0.
REQ-028 In RESP with rsp_ready=1 the block SHALL return to IDLE next cycle; a new request is accepted no earlier than the cycle after RESP exits (no same-cycle turnaround).
REQ-029 mul_done outside WAIT_MUL SHALL be ignored.
REQ-030 op_a/op_b SHALL hold their value from handshake until the next handshake.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, req_ready=1, rsp_valid=0, mul_start=0, rsp_err=0, rsp_result=0, op_a=op_b=0, {s1,s0}=11, counter=0.
REQ-032 rst asserted mid-operation (ISSUE/WAIT_MUL/RESP) SHALL abandon the request with no response; a later mul_done SHALL be ignored.

Verification
REQ-033 add: req op=00 a=5 b=3, mux_result=8 -> {s1,s0}=00, rsp_valid at handshake+2, rsp_result=8, rsp_err=0.
REQ-034 mul: op=10 a=9 b=4, mul_done after 3 cycles with mux_result=36 -> single mul_start pulse, {s1,s0}=10, rsp_result=36, rsp_err=0.
REQ-035 timeout: op=10, mul_done never asserted, MUL_TIMEOUT=15 -> RESP after 15 WAIT_MUL cycles, rsp_result=0, rsp_err=1.
REQ-036 illegal: op=11 -> rsp_err=1, rsp_result=0, mul_start never asserted, {s1,s0}=11.
REQ-037 backpressure: sub response with rsp_ready=0 for 4 cycles -> rsp_valid/rsp_result stable, req_ready=0 throughout, IDLE one cycle after rsp_ready=1.
REQ-038 reset mid-mul: rst pulse in WAIT_MUL, then mul_done=1 -> all outputs at reset values, no rsp_valid.
